uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver that consumes the serial stream produced by the on-board message transmitter. Same line format: 8N1, LSB first, idle high, 434 clk_50 cycles per bit (115200 baud at 50 MHz).
- Deserialises each frame, checks the start and stop bits, and buffers received bytes in a small first-word-fall-through (FWFT) FIFO for a downstream consumer.
- Reports framing errors and FIFO overflow through sticky flags.

Parameters:
- CLKS_PER_BIT, 434, clk_50 cycles per bit period.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, asynchronous to clk_50, idle high.
- rd_en  in  1  pop request; honoured only when empty=0.
- rd_data  out  8  FIFO head byte; valid whenever empty=0.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- count  out  ADDR_W+1  number of bytes held.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; both synchroniser flops = 1; bit counters 0.
  - FIFO pointers 0: empty=1, full=0, count=0, rd_data=0.
  - frame_err=0, overflow=0.
  - Asserting reset mid-frame abandons the partial byte; nothing is pushed.
- Input synchronisation: rx passes through 2 flops (rx_s). All FSM decisions use rx_s only.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- States:
  - IDLE: when rx_s=0 -> START.
  - START: at count=(CLKS_PER_BIT-1)/2 (=216), sample rx_s. If 0 -> DATA with bit_idx=0. If 1 -> IDLE (glitch rejected, no flag).
  - DATA: at count=CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] (LSB first). After bit_idx=7 -> STOP; otherwise bit_idx+1.
  - STOP: at count=CLKS_PER_BIT-1, sample rx_s.
    - If 1: push shift into the FIFO -> IDLE.
    - If 0: set frame_err, discard the byte -> BREAK.
  - BREAK: wait until rx_s=1 -> IDLE. No start detection while in BREAK.
- Push and pop are evaluated on the same clock edge, using the FIFO state before that edge:
  - Push when not full: write at wr_ptr; wr_ptr+1 with wrap modulo FIFO_DEPTH.
  - Push when full and no pop in the same cycle: byte dropped, overflow=1, contents unchanged.
  - Push when full with a pop in the same cycle: both performed; count stays FIFO_DEPTH; no overflow.
  - Pop (rd_en=1 and empty=0): rd_ptr+1 with wrap.
  - rd_en while empty: ignored; pointers unchanged.
  - Push while empty with rd_en=1: push only; the new byte is not popped that cycle.
- count, empty, full and rd_data are registered. They reflect a push or pop on the cycle after it.
- Latency: the pushed byte appears on rd_data, with empty=0, 1 cycle after the stop-bit sample edge.
- Sticky flags:
  - Set by the events above; cleared by clr_err=1.
  - If a set event and clr_err occur in the same cycle, set wins (flag=1).
  - Flags do not block reception.

Test Plan:
- Send 0x65 ('e') as a 434-cycle/bit frame. Required: empty falls, rd_data=0x65, count=1. Then pulse rd_en for 1 cycle. Required: empty=1, count=0.
- Send "eYRC" back-to-back with no reads. Required: full=1, count=4. Then 4 pops. Required: rd_data sequence 0x65, 0x59, 0x52, 0x43, then empty=1.
- With the FIFO full, send 0x2D. Required: overflow=1 and the contents still read 0x65..0x43. Then clr_err. Required: overflow=0. Repeat the send with rd_en held during the stop-sample cycle. Required: 0x2D accepted, overflow=0.
- Drive rx low for 100 cycles, then high. Required: no push, no flags, FSM back in IDLE. A following 0x41 frame is received correctly.
- Hold rx low for 20 bit times. Required: frame_err=1, no push. After rx returns high, send 0x0A. Required: rd_data=0x0A.
- Assert rst_n low during DATA bit 4. Required: all outputs at reset values immediately. Release reset and send 0x43. Required: rd_data=0x43, count=1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side bundle: serial line in, FWFT FIFO read port and sticky status out.
// The slave modport is the receiver; the master modport is the consumer / line driver.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 2
) ();
  logic              rx;
  logic              rd_en;
  logic              clr_err;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              frame_err;
  logic              overflow;

  modport slave (
    input  rx,
    input  rd_en,
    input  clr_err,
    output rd_data,
    output empty,
    output full,
    output count,
    output frame_err,
    output overflow
  );

  modport master (
    output rx,
    output rd_en,
    output clr_err,
    input  rd_data,
    input  empty,
    input  full,
    input  count,
    input  frame_err,
    input  overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small FWFT byte FIFO; byte visible on rd_data the cycle after the stop sample.
// No backpressure on the line: a byte arriving at a full FIFO is dropped and flagged unless popped that cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input logic           clk_50,
  input logic           rst_n,
  uart_rx_fifo_if.slave rx_bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_s1;
  logic              r_rx_s2;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              w_baud_mid;
  logic              w_baud_last;
  logic              w_bit_adv;
  logic              w_push;
  logic              w_ferr_set;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_empty;
  logic              r_full;
  logic [7:0]        r_rd_data;
  logic [7:0]        w_head_nxt;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_ovf_set;
  logic              r_frame_err;
  logic              r_overflow;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx_bus.rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_baud_mid  = (r_baud == BAUD_MID);
  assign w_baud_last = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_adv   = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s2) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_baud_mid) w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_bit_adv = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          if (r_rx_s2) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_baud_last) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (w_bit_adv) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_bit_adv) r_shift[r_bit_idx] <= r_rx_s2;
    end
  end

  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign w_pop        = rx_bus.rd_en && !r_empty;
  assign w_wr_en      = w_push && (!r_full || w_pop);
  assign w_ovf_set    = w_push && r_full && !w_pop;
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + ADDR_W'(1)) : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_wr_en && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // The next head is the incoming byte when it lands in the slot the read pointer moves to.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = r_shift;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == DEPTH_C);
      if (w_wr_en || w_pop) r_rd_data <= w_head_nxt;
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err keeps the flag high.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (rx_bus.clr_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (rx_bus.clr_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign rx_bus.rd_data   = r_rd_data;
  assign rx_bus.empty     = r_empty;
  assign rx_bus.full      = r_full;
  assign rx_bus.count     = r_count;
  assign rx_bus.frame_err = r_frame_err;
  assign rx_bus.overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives 8N1 frames cycle by cycle and checks FIFO contents and flags.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;
  localparam int CPB    = 434;
  localparam int FRAME  = 10 * CPB;
  // Iteration whose driven value is sampled on the stop-bit decision edge:
  // 2 sync flops + 1 IDLE->START edge, mid-start wait, 8 data bits, full stop bit count.
  localparam int STOP_C = (CPB - 1) / 2 + 9 * CPB + 3;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;

  uart_rx_fifo_if #(.ADDR_W(2)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .ADDR_W      (2)
  ) dut (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .rx_bus(bus)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic rx_low(input int n);
    bus.rx = 1'b0;
    tick(n);
    bus.rx = 1'b1;
  endtask

  // Drives ncyc cycles of a frame; optional rd_en / clr_err pulse on the stop-decision cycle.
  task automatic send(input logic [7:0] d, input int ncyc, input bit pop_stop,
                      input bit clr_stop, input bit lat);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      bus.rx = fr[4'(c / CPB)];
      if (pop_stop) bus.rd_en = (c == STOP_C);
      if (clr_stop) bus.clr_err = (c == STOP_C);
      if (lat && c == STOP_C) chk("lat_still_empty", 32'(bus.empty), 32'd1);
      if (lat && c == STOP_C + 1) begin
        chk("lat_empty_fall", 32'(bus.empty), 32'd0);
        chk("lat_rd_data", 32'(bus.rd_data), 32'(d));
      end
      tick(1);
    end
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    logic [7:0] word  [4];
    exp_q = '{8'h59, 8'h52, 8'h43, 8'h2D};
    word  = '{8'h65, 8'h59, 8'h52, 8'h43};

    bus.rx      = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    #5 rst_n = 1'b0;
    #2;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Single byte, with latency check around the stop decision edge.
    send(8'h65, FRAME, 1'b0, 1'b0, 1'b1);
    chk("e_rd_data", 32'(bus.rd_data), 32'h65);
    chk("e_count", 32'(bus.count), 32'd1);
    pop();
    chk("e_pop_empty", 32'(bus.empty), 32'd1);
    chk("e_pop_count", 32'(bus.count), 32'd0);
    pop();
    chk("pop_on_empty_count", 32'(bus.count), 32'd0);

    // Fill with "eYRC".
    for (int i = 0; i < 4; i++) send(word[i], FRAME, 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_head", 32'(bus.rd_data), 32'h65);
    chk("fill_no_ovf", 32'(bus.overflow), 32'd0);

    // Overflow with clr_err on the same edge: set wins.
    send(8'h2D, FRAME, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_head", 32'(bus.rd_data), 32'h65);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Push into full FIFO with a same-cycle pop.
    send(8'h2D, FRAME, 1'b1, 1'b0, 1'b0);
    chk("pp_no_ovf", 32'(bus.overflow), 32'd0);
    chk("pp_count", 32'(bus.count), 32'd4);
    chk("pp_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(exp_q[i]));
      pop();
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Short low glitch is rejected at the mid-start sample.
    rx_low(100);
    tick(400);
    chk("glitch_empty", 32'(bus.empty), 32'd1);
    chk("glitch_ferr", 32'(bus.frame_err), 32'd0);
    chk("glitch_ovf", 32'(bus.overflow), 32'd0);
    send(8'h41, FRAME, 1'b0, 1'b0, 1'b0);
    chk("A_rd_data", 32'(bus.rd_data), 32'h41);
    chk("A_count", 32'(bus.count), 32'd1);
    pop();

    // Line break: framing error, nothing pushed, reception resumes.
    rx_low(20 * CPB);
    tick(10);
    chk("brk_ferr", 32'(bus.frame_err), 32'd1);
    chk("brk_empty", 32'(bus.empty), 32'd1);
    send(8'h0A, FRAME, 1'b0, 1'b0, 1'b0);
    chk("lf_rd_data", 32'(bus.rd_data), 32'h0A);
    chk("lf_count", 32'(bus.count), 32'd1);
    chk("lf_ferr_sticky", 32'(bus.frame_err), 32'd1);

    // Reset in the middle of data bit 4.
    send(8'h43, 5 * CPB + CPB / 2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    bus.rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);
    send(8'h43, FRAME, 1'b0, 1'b0, 1'b0);
    chk("C_rd_data", 32'(bus.rd_data), 32'h43);
    chk("C_count", 32'(bus.count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
